// File: rtl/nv_nvdla_noc_axi_wr_rsp_gen.sv
// Purpose: memory-side AXI write responder; counts W beats per AW burst, returns one in-order B per burst.
// Latency: last W handshake in cycle t -> bvalid no earlier than t+1+B_LAT (B queue empty before).
// Backpressure: awready drops when the AW queue is full; wready drops when no AW is queued or the B queue is full.

// Generic synchronous FIFO: registered storage, head visible combinationally, no bypass.
module nv_nvdla_noc_axi_wr_rsp_gen_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Pointer advance and storage write; callers never push when full or pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // State registers; storage cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q[PW-1:0]];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// Purpose: AXI write-response generator endpoint for the MCIF write path.
// Latency: B for a burst ends B_LAT+1 cycles after its last W beat at the earliest.
// Backpressure: AW held off when AW queue full; W held off until its AW is queued and a B slot is free.
module nv_nvdla_noc_axi_wr_rsp_gen #(
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 4,
  parameter int B_LAT    = 2
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       mcif2noc_axi_aw_awvalid,
  output logic       mcif2noc_axi_aw_awready,
  input  logic [7:0] mcif2noc_axi_aw_awid,
  input  logic [3:0] mcif2noc_axi_aw_awlen,
  input  logic       mcif2noc_axi_w_wvalid,
  output logic       mcif2noc_axi_w_wready,
  input  logic       mcif2noc_axi_w_wlast,
  output logic       noc2mcif_axi_b_bvalid,
  input  logic       noc2mcif_axi_b_bready,
  output logic [7:0] noc2mcif_axi_b_bid,
  output logic [7:0] rsp_outstanding,
  output logic       wlast_err
);

  typedef struct packed {
    logic [7:0] id;
    logic [3:0] len;
  } aw_ent_t;

  localparam logic [3:0] B_LAT_C = 4'(B_LAT);

  aw_ent_t    aw_push_ent;
  aw_ent_t    aw_head;
  logic       aw_empty, aw_full;
  logic       b_empty, b_full;
  logic [7:0] b_head_id;

  logic       aw_hs, w_hs, b_pop, b_push, last_beat;

  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] age_q, age_d;
  logic [7:0] outstanding_q, outstanding_d;
  logic       wlast_err_q, wlast_err_d;

  assign aw_push_ent.id  = mcif2noc_axi_aw_awid;
  assign aw_push_ent.len = mcif2noc_axi_aw_awlen;

  // Handshakes and burst-end detection; burst length comes from awlen alone.
  assign mcif2noc_axi_aw_awready = !aw_full;
  assign mcif2noc_axi_w_wready   = !aw_empty && !b_full;
  assign aw_hs     = mcif2noc_axi_aw_awvalid && mcif2noc_axi_aw_awready;
  assign w_hs      = mcif2noc_axi_w_wvalid && mcif2noc_axi_w_wready;
  assign last_beat = (beat_cnt_q == aw_head.len);
  assign b_push    = w_hs && last_beat;

  assign noc2mcif_axi_b_bvalid = !b_empty && (age_q >= B_LAT_C);
  assign noc2mcif_axi_b_bid    = b_empty ? 8'h00 : b_head_id;
  assign b_pop                 = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;

  assign rsp_outstanding = outstanding_q;
  assign wlast_err       = wlast_err_q;

  // Queue of accepted AW commands awaiting their W beats.
  nv_nvdla_noc_axi_wr_rsp_gen_fifo #(
    .DEPTH (AW_DEPTH),
    .WIDTH ($bits(aw_ent_t))
  ) u_aw_fifo (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .push     (aw_hs),
    .push_dat (aw_push_ent),
    .pop      (b_push),
    .head_dat (aw_head),
    .empty    (aw_empty),
    .full     (aw_full)
  );

  // Queue of completed bursts awaiting their B handshake, in AW order.
  nv_nvdla_noc_axi_wr_rsp_gen_fifo #(
    .DEPTH (B_DEPTH),
    .WIDTH (8)
  ) u_b_fifo (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .push     (b_push),
    .push_dat (aw_head.id),
    .pop      (b_pop),
    .head_dat (b_head_id),
    .empty    (b_empty),
    .full     (b_full)
  );

  // Beat counter within the head burst and the sticky wlast consistency flag.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    wlast_err_d = wlast_err_q;
    if (w_hs) begin
      beat_cnt_d = last_beat ? 4'd0 : beat_cnt_q + 4'd1;
      if (mcif2noc_axi_w_wlast != last_beat) begin
        wlast_err_d = 1'b1;
      end
    end
  end

  // Head age: restarts whenever a new entry becomes the B head, saturates at 15, frozen once valid.
  always_comb begin
    age_d = age_q;
    if (b_pop || (b_push && b_empty)) begin
      age_d = 4'd0;
    end else if (!noc2mcif_axi_b_bvalid && (age_q != 4'hF)) begin
      age_d = age_q + 4'd1;
    end
  end

  // Bursts in flight from AW acceptance to B handshake; bounded by the two queue depths.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({aw_hs, b_pop})
      2'b10:   outstanding_d = outstanding_q + 8'd1;
      2'b01:   outstanding_d = outstanding_q - 8'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_cnt_q    <= 4'd0;
      age_q         <= 4'd0;
      outstanding_q <= 8'd0;
      wlast_err_q   <= 1'b0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      age_q         <= age_d;
      outstanding_q <= outstanding_d;
      wlast_err_q   <= wlast_err_d;
    end
  end

endmodule
